// File: rtl/seg_display_mux.sv
// seg_display_mux -- four-digit multiplexed seven-segment display driver.
//
// Scans four BCD digits onto a common-anode display, one digit per slot of
// SCAN_DIV clk5 cycles. The digits and the decimal-point requests are
// captured into shadow registers once per frame, so a frame is never torn.
// All display outputs are registered and lag the scan index by one cycle.
//
// Parameters:
//   SCAN_DIV  clk5 cycles per digit slot (legal range 2..65535)
//
// Ports:
//   clk5         system clock, rising edge
//   reset        asynchronous reset, active-low
//   digit0..3    BCD digits (ones..thousands)
//   dp_pos       decimal point request, bit n = digit n, active-high
//   an           anode enables, active-low, bit n = digit n
//   seg          cathodes {g,f,e,d,c,b,a}, active-low
//   dp           decimal point cathode, active-low
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zeros on digits 3..1 are
//                          blanked (digit0 is always shown).

module seg_display_mux #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_pos,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned   PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  // ST_LOAD is the single cycle after reset release that only loads the
  // shadow; scanning (prescaler, index, outputs) begins in ST_SCAN.
  typedef enum logic {ST_LOAD, ST_SCAN} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_sh_d0;
  logic [3:0]    r_sh_d1;
  logic [3:0]    r_sh_d2;
  logic [3:0]    r_sh_d3;
  logic [3:0]    r_sh_dp;

  logic          w_presc_last;
  logic [3:0]    w_sel_digit;
  logic          w_sel_dp;
  logic [3:0]    w_blank;
  logic          w_sel_blank;
  logic [6:0]    w_seg_dec;

  always_comb begin
    w_presc_last = (r_presc == PRESC_LAST);

    case (r_idx)
      2'd0:    w_sel_digit = r_sh_d0;
      2'd1:    w_sel_digit = r_sh_d1;
      2'd2:    w_sel_digit = r_sh_d2;
      default: w_sel_digit = r_sh_d3;
    endcase
    w_sel_dp = r_sh_dp[r_idx];

    w_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    // Each blank condition chains from the more significant digit.
    w_blank[3] = (r_sh_d3 == 4'd0);
    w_blank[2] = w_blank[3] && (r_sh_d2 == 4'd0);
    w_blank[1] = w_blank[2] && (r_sh_d1 == 4'd0);
`else
    w_blank = '0;
`endif
    w_sel_blank = w_blank[r_idx];

    case (w_sel_digit)
      4'd0:    w_seg_dec = 7'b1000000;
      4'd1:    w_seg_dec = 7'b1111001;
      4'd2:    w_seg_dec = 7'b0100100;
      4'd3:    w_seg_dec = 7'b0110000;
      4'd4:    w_seg_dec = 7'b0011001;
      4'd5:    w_seg_dec = 7'b0010010;
      4'd6:    w_seg_dec = 7'b0000010;
      4'd7:    w_seg_dec = 7'b1111000;
      4'd8:    w_seg_dec = 7'b0000000;
      4'd9:    w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      r_state <= ST_LOAD;
      r_presc <= '0;
      r_idx   <= '0;
      r_sh_d0 <= '0;
      r_sh_d1 <= '0;
      r_sh_d2 <= '0;
      r_sh_d3 <= '0;
      r_sh_dp <= '0;
      an      <= '1;
      seg     <= '1;
      dp      <= 1'b1;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_sh_d0 <= digit0;
          r_sh_d1 <= digit1;
          r_sh_d2 <= digit2;
          r_sh_d3 <= digit3;
          r_sh_dp <= dp_pos;
          r_state <= ST_SCAN;
        end
        default: begin
          if (w_sel_blank) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
          end else begin
            an  <= ~(4'b0001 << r_idx);
            seg <= w_seg_dec;
            dp  <= ~w_sel_dp;
          end

          if (w_presc_last) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
            // Recapture as index 3 wraps; this edge still shows the old
            // digit 3, the next edge shows the new digit 0.
            if (r_idx == 2'd3) begin
              r_sh_d0 <= digit0;
              r_sh_d1 <= digit1;
              r_sh_d2 <= digit2;
              r_sh_d3 <= digit3;
              r_sh_dp <= dp_pos;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
module tb_seg_display_mux;

  localparam int unsigned SCAN_DIV = 4;

  logic       clk5;
  logic       reset;
  logic [3:0] digit0, digit1, digit2, digit3, dp_pos;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [3:0] p0, p1, p2, p3, pdp;

  seg_display_mux #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk5   (clk5),
    .reset  (reset),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .dp_pos (dp_pos),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial clk5 = 1'b0;
  always #5 clk5 = ~clk5;

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk5);
    #1;
  endtask

  task automatic check(input string tag, input exp_t e);
    n_cmp++;
    assert ({an, seg, dp} === e) else begin
      n_fail++;
      $error("FAIL %s: an/seg/dp = %b/%b/%b, expected %b/%b/%b",
             tag, an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  task automatic check_blank(input string tag);
    exp_t e;
    e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
    check(tag, e);
  endtask

  // Expected outputs for one full frame (4 slots x SCAN_DIV cycles).
  task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3,
                            input logic [3:0] dpp);
    logic [3:0] d[4];
    logic [3:0] blk;
    exp_t e;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    blk = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    blk[3] = (d3 == 4'd0);
    blk[2] = blk[3] && (d2 == 4'd0);
    blk[1] = blk[2] && (d1 == 4'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      if (blk[k]) begin
        e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
      end else begin
        e.an  = 4'b1111;
        e.an[k] = 1'b0;
        e.seg = exp_seg(d[k]);
        e.dp  = ~dpp[k];
      end
      for (int c = 0; c < int'(SCAN_DIV); c++) q.push_back(e);
    end
  endtask

  task automatic run(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL %s: scoreboard empty, got an=%b, expected a queued entry", tag, an);
      end else begin
        e = q.pop_front();
        check(tag, e);
      end
      n_cmp++;
      assert ($countones(~an) <= 1) else begin
        n_fail++;
        $error("FAIL %s_onehot: an=%b, expected at most one low bit", tag, an);
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    digit0 = 4'd1; digit1 = 4'd2; digit2 = 4'd3; digit3 = 4'd4;
    dp_pos = 4'b0000;

    // Reset held: outputs stay at reset values while clocking.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_blank("reset_hold");
    end

    // Release between edges; edge 1 loads the shadow, edge 2 shows digit0.
    #3 reset = 1'b1;
    tick();
    push_frame(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    push_frame(4'd7, 4'd2, 4'd3, 4'd4, 4'b0000);
    run(5, "frame1234");
    // Now in the digit1 slot: change digit0, must not tear this frame.
    digit0 = 4'd7;
    run(27, "nottorn");

    // Leading-zero pattern 5,0,0,0.
    digit0 = 4'd5; digit1 = 4'd0; digit2 = 4'd0; digit3 = 4'd0;
    push_frame(4'd7, 4'd2, 4'd3, 4'd4, 4'b0000);
    push_frame(4'd5, 4'd0, 4'd0, 4'd0, 4'b0000);
    run(32, "lzb5000");

    // Dash for digit value 12, decimal point on digit1.
    digit0 = 4'd3; digit1 = 4'd9; digit2 = 4'd12; digit3 = 4'd8;
    dp_pos = 4'b0010;
    push_frame(4'd5, 4'd0, 4'd0, 4'd0, 4'b0000);
    push_frame(4'd3, 4'd9, 4'd12, 4'd8, 4'b0010);
    run(32, "dash_dp");

    // Random digits: each frame shows what was applied one frame earlier.
    p0 = 4'd3; p1 = 4'd9; p2 = 4'd12; p3 = 4'd8; pdp = 4'b0010;
    for (int f = 0; f < 4; f++) begin
      digit0 = 4'($urandom_range(15, 0));
      digit1 = 4'($urandom_range(15, 0));
      digit2 = 4'($urandom_range(15, 0));
      digit3 = 4'($urandom_range(15, 0));
      dp_pos = 4'($urandom_range(15, 0));
      push_frame(p0, p1, p2, p3, pdp);
      run(16, "random");
      p0 = digit0; p1 = digit1; p2 = digit2; p3 = digit3; pdp = dp_pos;
    end

    // Reach index 2, prescaler 1, then assert reset asynchronously.
    push_frame(p0, p1, p2, p3, pdp);
    run(9, "pre_abort");
    q.delete();
    #2 reset = 1'b0;
    #1 check_blank("async_rst");
    tick();
    check_blank("rst_hold2");
    tick();
    check_blank("rst_hold3");

    digit0 = 4'd6; digit1 = 4'd0; digit2 = 4'd4; digit3 = 4'd0;
    dp_pos = 4'b1001;
    #3 reset = 1'b1;
    tick();
    push_frame(4'd6, 4'd0, 4'd4, 4'd0, 4'b1001);
    run(16, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
